// File: rtl/serial_cla_subtractor_pkg.sv
// Shared types and helpers for the serial nibble-wide CLA subtractor.
package serial_cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/serial_cla_subtractor_if.sv
// Request/response bundle for serial_cla_subtractor.
// Macro SERIAL_SUB_ADD_MODE_EN adds the op select (1 = add).
interface serial_cla_subtractor_if #(parameter int WIDTH = 16);

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             op;
`endif
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
`ifdef SERIAL_SUB_ADD_MODE_EN
        output op,
`endif
        output start_valid, a, b, bin, res_ready,
        input  start_ready, res_valid, diff, bout, ovf
    );

    modport slave (
`ifdef SERIAL_SUB_ADD_MODE_EN
        input  op,
`endif
        input  start_valid, a, b, bin, res_ready,
        output start_ready, res_valid, diff, bout, ovf
    );

endinterface

// File: rtl/serial_cla_subtractor_nibble.sv
// Combinational 4-bit carry-lookahead cell; inv_b turns it into a - b - ~cin.
module nibble_borrow_unit (
    input  logic [3:0] a_n,
    input  logic [3:0] b_n,
    input  logic       cin,
    input  logic       inv_b,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] bb;
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign bb = b_n ^ {4{inv_b}};
    assign p  = a_n ^ bb;
    assign g  = a_n & bb;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;

endmodule

// File: rtl/serial_cla_subtractor.sv
// Serial WIDTH-bit subtractor, one CLA nibble per clock, LSB nibble first.
// Macro SERIAL_SUB_ADD_MODE_EN enables the op port (op=1 adds instead).
//
// state | meaning
// IDLE  | start_ready=1, waiting for a request
// RUN   | one nibble step per clock, idx counts up to NIB-1
// DONE  | res_valid=1, outputs frozen until res_ready
module serial_cla_subtractor
    import serial_cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    serial_cla_subtractor_if.slave bus
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   diff_q;
    logic [IDX_W-1:0]   idx_q;
    logic               c_q;
    logic               inv_q;
    logic               bout_q;
    logic               ovf_q;
    logic               start_ready_q;
    logic               res_valid_q;

    logic [3:0]         a_n;
    logic [3:0]         b_n;
    logic [3:0]         s_n;
    logic               cout_n;

    assign a_n = a_q[{idx_q, 2'b00} +: NIB_W];
    assign b_n = b_q[{idx_q, 2'b00} +: NIB_W];

    nibble_borrow_unit u_nib (
        .a_n   (a_n),
        .b_n   (b_n),
        .cin   (c_q),
        .inv_b (inv_q),
        .sum   (s_n),
        .cout  (cout_n)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            diff_q        <= '0;
            idx_q         <= '0;
            c_q           <= 1'b0;
            inv_q         <= 1'b1;
            bout_q        <= 1'b0;
            ovf_q         <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid && start_ready_q) begin
                        a_q           <= bus.a;
                        b_q           <= bus.b;
`ifdef SERIAL_SUB_ADD_MODE_EN
                        inv_q         <= ~bus.op;
                        c_q           <= bus.op ? bus.bin : ~bus.bin;
`else
                        inv_q         <= 1'b1;
                        c_q           <= ~bus.bin;
`endif
                        idx_q         <= '0;
                        start_ready_q <= 1'b0;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    diff_q[{idx_q, 2'b00} +: NIB_W] <= s_n;
                    c_q <= cout_n;
                    if (idx_q == IDX_W'(NIB - 1)) begin
                        // On the top nibble a_n[3]/b_n[3] are the operand sign bits.
                        bout_q      <= inv_q ? ~cout_n : cout_n;
                        ovf_q       <= (a_n[3] == (b_n[3] ^ inv_q)) && (s_n[3] != a_n[3]);
                        res_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q   <= 1'b0;
                        start_ready_q <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.diff        = diff_q;
    assign bus.bout        = bout_q;
    assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_serial_cla_subtractor.sv
// Scoreboard bench for serial_cla_subtractor at WIDTH=16.
module tb_serial_cla_subtractor;

    localparam int WIDTH = 16;
    localparam int NIB   = 4;

    typedef struct packed {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    serial_cla_subtractor_if #(.WIDTH(WIDTH)) ifc ();

    serial_cla_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic bin, input logic op);
        exp_t        e;
        logic [16:0] f;
        if (op) begin
            f     = {1'b0, a} + {1'b0, b} + {16'd0, bin};
            e.ovf = (a[15] == b[15]) && (f[15] != a[15]);
        end else begin
            f     = {1'b0, a} - {1'b0, b} - {16'd0, bin};
            e.ovf = (a[15] != b[15]) && (f[15] != a[15]);
        end
        e.diff = f[15:0];
        e.bout = f[16];
        return e;
    endfunction

    // Drives one request from IDLE, pushes its expectation, waits (bounded) for res_valid.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input logic op, output int lat);
        logic eff_op;
`ifdef SERIAL_SUB_ADD_MODE_EN
        eff_op = op;
        ifc.op = op;
`else
        eff_op = 1'b0;
`endif
        ifc.a = a;
        ifc.b = b;
        ifc.bin = bin;
        ifc.start_valid = 1'b1;
        sb.push_back(model(a, b, bin, eff_op));
        @(posedge clk); #1;
        ifc.start_valid = 1'b0;
        lat = 0;
        while (!ifc.res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        ifc.res_ready = 1'b1;
        @(posedge clk); #1;
        ifc.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ifc.start_ready !== 1'b1 || ifc.res_valid !== 1'b0 || ifc.diff !== 16'h0 ||
            ifc.bout !== 1'b0 || ifc.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b vld=%b diff=%h bout=%b ovf=%b want 1 0 0000 0 0",
                     ifc.start_ready, ifc.res_valid, ifc.diff, ifc.bout, ifc.ovf);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input logic [15:0] a, input logic [15:0] b, input logic bin,
                              input logic [15:0] want_diff, input logic want_bout,
                              input logic want_ovf, input string name);
        int   lat;
        exp_t e;
        run_op(a, b, bin, 1'b0, lat);
        checks++;
        if (lat !== NIB || ifc.res_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles vld=%b want %0d", name, lat, ifc.res_valid, NIB);
        end
        e = sb.pop_front();
        checks++;
        if (ifc.diff !== e.diff || ifc.bout !== e.bout || ifc.ovf !== e.ovf) begin
            errors++;
            $display("FAIL %s_result: got %h/%b/%b want %h/%b/%b", name,
                     ifc.diff, ifc.bout, ifc.ovf, e.diff, e.bout, e.ovf);
        end
        checks++;
        if (ifc.diff !== want_diff || ifc.bout !== want_bout || ifc.ovf !== want_ovf) begin
            errors++;
            $display("FAIL %s_literal: got %h/%b/%b want %h/%b/%b", name,
                     ifc.diff, ifc.bout, ifc.ovf, want_diff, want_bout, want_ovf);
        end
        release_result();
        checks++;
        if (ifc.start_ready !== 1'b1 || ifc.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: got rdy=%b vld=%b want 1 0", name, ifc.start_ready, ifc.res_valid);
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t e;
        run_op(16'hA5C3, 16'h3C5A, 1'b1, 1'b0, lat);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            ifc.start_valid = 1'b1;
            ifc.a = 16'($urandom);
            ifc.b = 16'($urandom);
            ifc.bin = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (ifc.diff !== e.diff || ifc.bout !== e.bout || ifc.ovf !== e.ovf ||
                ifc.start_ready !== 1'b0 || ifc.res_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold%0d: got %h/%b/%b rdy=%b vld=%b want %h/%b/%b rdy=0 vld=1",
                         i, ifc.diff, ifc.bout, ifc.ovf, ifc.start_ready, ifc.res_valid,
                         e.diff, e.bout, e.ovf);
            end
        end
        ifc.start_valid = 1'b0;
        release_result();
        checks++;
        if (ifc.start_ready !== 1'b1 || ifc.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: got rdy=%b vld=%b want 1 0", ifc.start_ready, ifc.res_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ifc.start_ready !== 1'b1 || ifc.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_no_accept: got rdy=%b vld=%b want 1 0", ifc.start_ready, ifc.res_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int   lat;
        logic seen;
        ifc.a = 16'h1234;
        ifc.b = 16'h4321;
        ifc.bin = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
        ifc.op = 1'b0;
`endif
        ifc.start_valid = 1'b1;
        @(posedge clk); #1;
        ifc.start_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (ifc.start_ready !== 1'b1 || ifc.res_valid !== 1'b0 || ifc.diff !== 16'h0 ||
            ifc.bout !== 1'b0 || ifc.ovf !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_values: got rdy=%b vld=%b diff=%h bout=%b ovf=%b want 1 0 0000 0 0",
                     ifc.start_ready, ifc.res_valid, ifc.diff, ifc.bout, ifc.ovf);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ifc.res_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_result: got res_valid asserted want never");
        end
        test_basic(16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_add_mode();
        int          lat;
        exp_t        e;
        logic [15:0] want;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, lat);
`ifdef SERIAL_SUB_ADD_MODE_EN
        want = 16'h8000;
`else
        want = 16'h7FFE;
`endif
        e = sb.pop_front();
        checks++;
        if (ifc.res_valid !== 1'b1 || ifc.diff !== want || ifc.diff !== e.diff ||
            ifc.bout !== e.bout || ifc.ovf !== e.ovf) begin
            errors++;
            $display("FAIL add_mode: got vld=%b %h/%b/%b want %h/%b/%b", ifc.res_valid,
                     ifc.diff, ifc.bout, ifc.ovf, want, e.bout, e.ovf);
        end
        release_result();
`ifdef SERIAL_SUB_ADD_MODE_EN
        run_op(16'hFFFF, 16'h0001, 1'b1, 1'b1, lat);
        e = sb.pop_front();
        checks++;
        if (ifc.diff !== e.diff || ifc.bout !== e.bout || ifc.ovf !== e.ovf) begin
            errors++;
            $display("FAIL add_carry: got %h/%b/%b want %h/%b/%b",
                     ifc.diff, ifc.bout, ifc.ovf, e.diff, e.bout, e.ovf);
        end
        release_result();
`endif
    endtask

    task automatic test_back_to_back();
        int   lat;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), lat);
            e = sb.pop_front();
            checks++;
            if (lat !== NIB || ifc.diff !== e.diff || ifc.bout !== e.bout || ifc.ovf !== e.ovf) begin
                errors++;
                $display("FAIL random%0d: got lat=%0d %h/%b/%b want lat=%0d %h/%b/%b", i, lat,
                         ifc.diff, ifc.bout, ifc.ovf, NIB, e.diff, e.bout, e.ovf);
            end
            release_result();
        end
    endtask

    initial begin
        ifc.start_valid = 1'b0;
        ifc.res_ready = 1'b0;
        ifc.a = '0;
        ifc.b = '0;
        ifc.bin = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
        ifc.op = 1'b0;
`endif
        test_reset();
        test_basic(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, "basic");
        test_basic(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "borrow_ripple");
        test_basic(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "overflow");
        test_basic(16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, "borrow_in");
        test_basic(16'h0003, 16'h0003, 1'b1, 16'hFFFF, 1'b1, 1'b0, "borrow_in_under");
        test_backpressure();
        test_reset_mid_run();
        test_add_mode();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
